// File: rtl/distrib_law_sweeper.sv
// Boolean-identity sweeper: steps {a,b,c} through every combination, counts lhs/rhs mismatches.
// Optional DLS_FAULT_INJECT_EN adds a fault_en input that corrupts rhs[0] whenever c[0] is set.
module distrib_law_sweeper #(
    parameter int unsigned W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       law,
`ifdef DLS_FAULT_INJECT_EN
    input  logic             fault_en,
`endif
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    output logic [W-1:0]     lhs,
    output logic [W-1:0]     rhs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3*W:0]     err_count,
    output logic [3*W-1:0]   first_fail
);

    localparam int unsigned VW = 3 * W;
    localparam int unsigned CW = 3 * W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [1:0]      law_q, law_d;
    logic [CW-1:0]   err_q, err_d;
    logic [VW-1:0]   ff_q, ff_d;
    logic            seen_q, seen_d;
    logic [W-1:0]    rhs_true;
    logic            mismatch;

    assign {a, b, c} = vec_q;

    // Both sides of the latched identity on the current operands
    always_comb begin
        lhs      = '0;
        rhs_true = '0;
        case (law_q)
            2'd0: begin
                lhs      = a & (b | c);
                rhs_true = (a & b) | (a & c);
            end
            2'd1: begin
                lhs      = a | (b & c);
                rhs_true = (a | b) & (a | c);
            end
            2'd2: begin
                lhs      = ~(a & b);
                rhs_true = ~a | ~b;
            end
            default: begin
                lhs      = a | (a & b);
                rhs_true = a;
            end
        endcase
`ifdef DLS_FAULT_INJECT_EN
        rhs = rhs_true ^ W'(fault_en & c[0]);
`else
        rhs = rhs_true;
`endif
        mismatch = (lhs != rhs);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            law_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            law_q   <= law_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            seen_q  <= seen_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        law_d   = law_q;
        err_d   = err_q;
        ff_d    = ff_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    law_d   = law;
                    vec_d   = '0;
                    err_d   = '0;
                    ff_d    = '0;
                    seen_d  = 1'b0;
                end
            end
            SWEEP: begin
                if (mismatch) begin
                    err_d = err_q + CW'(1);
                    if (!seen_q) begin
                        seen_d = 1'b1;
                        ff_d   = vec_q;
                    end
                end
                // Counter holds at all-ones in DONE rather than wrapping
                if (vec_q == '1) begin
                    state_d = DONE;
                end else begin
                    vec_d = vec_q + VW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q == SWEEP);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_distrib_law_sweeper.sv
// Bench for distrib_law_sweeper: directed and randomized sweeps at W=1 and W=2 against an arithmetic model.
// Honours DLS_FAULT_INJECT_EN to exercise the fault_en input when the design is built with it.
module tb_distrib_law_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic [1:0] law1, law2;
    logic       fault_en;
    bit         fe = 1'b0;

    logic [0:0] a1, b1, c1, lhs1, rhs1;
    logic       busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] ff1;

    logic [1:0] a2, b2, c2, lhs2, rhs2;
    logic       busy2, done2, pass2;
    logic [6:0] err2;
    logic [5:0] ff2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    distrib_law_sweeper #(.W(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .law(law1),
`ifdef DLS_FAULT_INJECT_EN
        .fault_en(fault_en),
`endif
        .a(a1), .b(b1), .c(c1), .lhs(lhs1), .rhs(rhs1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    distrib_law_sweeper #(.W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .law(law2),
`ifdef DLS_FAULT_INJECT_EN
        .fault_en(1'b0),
`endif
        .a(a2), .b(b2), .c(c2), .lhs(lhs2), .rhs(rhs2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Identity sides from plain integer arithmetic on the packed vector v = {a,b,c}
    function automatic int mdl_lhs(input int lw, input int w, input int v);
        int m = (1 << w) - 1;
        int a = (v >> (2 * w)) & m;
        int b = (v >> w) & m;
        int c = v & m;
        case (lw)
            0:       return a & (b | c);
            1:       return a | (b & c);
            2:       return (~(a & b)) & m;
            default: return a | (a & b);
        endcase
    endfunction

    function automatic int mdl_rhs(input int lw, input int w, input int v, input bit f);
        int m = (1 << w) - 1;
        int a = (v >> (2 * w)) & m;
        int b = (v >> w) & m;
        int c = v & m;
        int r;
        case (lw)
            0:       r = (a & b) | (a & c);
            1:       r = (a | b) & (a | c);
            2:       r = ((~a) | (~b)) & m;
            default: r = a;
        endcase
        if (f && (c % 2 == 1)) r = r ^ 1;
        return r;
    endfunction

    task automatic drv(input int w, input logic s, input logic [1:0] l);
        if (w == 1) begin start1 = s; law1 = l; end
        else        begin start2 = s; law2 = l; end
    endtask

    task automatic sample(input int w, output logic [31:0] v, output logic [31:0] lh,
                          output logic [31:0] rh, output logic [31:0] bs, output logic [31:0] dn,
                          output logic [31:0] ps, output logic [31:0] er, output logic [31:0] ff);
        if (w == 1) begin
            v = 32'({a1, b1, c1}); lh = 32'(lhs1); rh = 32'(rhs1);
            bs = 32'(busy1); dn = 32'(done1); ps = 32'(pass1); er = 32'(err1); ff = 32'(ff1);
        end else begin
            v = 32'({a2, b2, c2}); lh = 32'(lhs2); rh = 32'(rhs2);
            bs = 32'(busy2); dn = 32'(done2); ps = 32'(pass2); er = 32'(err2); ff = 32'(ff2);
        end
    endtask

    // Full sweep: start pulse, per-vector checks, final results; noise pokes start/law mid-sweep
    task automatic sweep(input int w, input int lw, input bit noise, output int errs, output int ffv);
        int n = 1 << (3 * w);
        logic [31:0] v, lh, rh, bs, dn, ps, er, ff;
        errs = 0;
        ffv  = 0;
        @(negedge clk);
        drv(w, 1'b1, 2'(lw));
        @(negedge clk);
        drv(w, 1'b0, noise ? 2'($urandom_range(0, 3)) : 2'(lw));
        for (int k = 0; k < n; k++) begin
            int el = mdl_lhs(lw, w, k);
            int er_ = mdl_rhs(lw, w, k, fe);
            sample(w, v, lh, rh, bs, dn, ps, er, ff);
            chk($sformatf("vec w%0d k%0d", w, k), v, 32'(k));
            chk($sformatf("lhs w%0d law%0d k%0d", w, lw, k), lh, 32'(el));
            chk($sformatf("rhs w%0d law%0d k%0d", w, lw, k), rh, 32'(er_));
            chk($sformatf("busy w%0d k%0d", w, k), bs, 32'd1);
            chk($sformatf("done w%0d k%0d", w, k), dn, 32'd0);
            chk($sformatf("run_err w%0d k%0d", w, k), er, 32'(errs));
            if (el != er_) begin
                if (errs == 0) ffv = k;
                errs++;
            end
            if (noise && k < n - 1)
                drv(w, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            else
                drv(w, 1'b0, 2'($urandom_range(0, 3)));
            @(negedge clk);
        end
        sample(w, v, lh, rh, bs, dn, ps, er, ff);
        chk($sformatf("end_busy w%0d law%0d", w, lw), bs, 32'd0);
        chk($sformatf("end_done w%0d law%0d", w, lw), dn, 32'd1);
        chk($sformatf("end_err w%0d law%0d", w, lw), er, 32'(errs));
        chk($sformatf("end_pass w%0d law%0d", w, lw), ps, 32'(errs == 0));
        chk($sformatf("end_ff w%0d law%0d", w, lw), ff, 32'(ffv));
        @(negedge clk);
        sample(w, v, lh, rh, bs, dn, ps, er, ff);
        chk($sformatf("hold_done w%0d", w), dn, 32'd1);
        chk($sformatf("hold_vec w%0d", w), v, 32'(n - 1));
    endtask

    initial begin
        int errs, ffv, w, lw;
        logic [31:0] v, lh, rh, bs, dn, ps, er, ff;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; law1 = 2'd0; law2 = 2'd0; fault_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int ww = 1; ww <= 2; ww++) begin
            sample(ww, v, lh, rh, bs, dn, ps, er, ff);
            chk($sformatf("rst_vec w%0d", ww), v, 32'd0);
            chk($sformatf("rst_busy w%0d", ww), bs, 32'd0);
            chk($sformatf("rst_done w%0d", ww), dn, 32'd0);
            chk($sformatf("rst_pass w%0d", ww), ps, 32'd0);
            chk($sformatf("rst_err w%0d", ww), er, 32'd0);
            chk($sformatf("rst_ff w%0d", ww), ff, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        sample(1, v, lh, rh, bs, dn, ps, er, ff);
        chk("idle_busy", bs, 32'd0);

        sweep(1, 0, 1'b0, errs, ffv);
        sweep(2, 1, 1'b0, errs, ffv);
        sweep(1, 2, 1'b0, errs, ffv);
        sweep(1, 3, 1'b0, errs, ffv);
        sweep(1, 0, 1'b1, errs, ffv);

        // Asynchronous reset landing mid-sweep
        @(negedge clk);
        drv(1, 1'b1, 2'($urandom_range(0, 3)));
        @(negedge clk);
        drv(1, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        sample(1, v, lh, rh, bs, dn, ps, er, ff);
        chk("pre_rst_vec", v, 32'd2);
        rst = 1'b1;
        #1;
        sample(1, v, lh, rh, bs, dn, ps, er, ff);
        chk("arst_busy", bs, 32'd0);
        chk("arst_err", er, 32'd0);
        chk("arst_vec", v, 32'd0);
        chk("arst_done", dn, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        sample(1, v, lh, rh, bs, dn, ps, er, ff);
        chk("post_rst_idle", bs, 32'd0);
        sweep(1, 1, 1'b0, errs, ffv);

        for (int i = 0; i < 8; i++) begin
            w  = $urandom_range(1, 2);
            lw = $urandom_range(0, 3);
            sweep(w, lw, 1'($urandom_range(0, 1)), errs, ffv);
        end

`ifdef DLS_FAULT_INJECT_EN
        fe = 1'b1;
        fault_en = 1'b1;
        sweep(1, 0, 1'b0, errs, ffv);
        chk("fault_err", 32'(err1), 32'd4);
        chk("fault_ff", 32'(ff1), 32'd1);
        chk("fault_pass", 32'(pass1), 32'd0);
        fe = 1'b0;
        fault_en = 1'b0;
        sweep(1, 0, 1'b0, errs, ffv);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
